// File: rtl/evt_pulse_gen_if.sv
// Burst-request and pulse-status signals shared by evt_pulse_gen and its requester.
// The master drives burst requests; the slave (the generator) drives the status outputs.
interface evt_pulse_gen_if #(
  parameter int WIDTH = 16
);
  logic             start_in;
  logic [WIDTH-1:0] count_in;
  logic [WIDTH-1:0] period_in;
  logic             abort_in;
  logic             evt_out;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] sent_out;

  modport master (
    output start_in, count_in, period_in, abort_in,
    input  evt_out, busy_out, done_out, sent_out
  );

  modport slave (
    input  start_in, count_in, period_in, abort_in,
    output evt_out, busy_out, done_out, sent_out
  );
endinterface

// File: rtl/evt_pulse_gen.sv
// Emits a burst of N single-cycle event pulses spaced P cycles apart, with
// busy/done status and a running tally; every output comes straight from a flop.
module evt_pulse_gen #(
  parameter int WIDTH = 16
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  evt_pulse_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] timer_q, timer_d;
  logic [WIDTH-1:0] sent_q, sent_d;
  logic             evt_q, evt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] p_eff;

  // A zero period degenerates to back-to-back pulses.
  assign p_eff = (bus.period_in == '0) ? ONE : bus.period_in;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    p_d     = p_q;
    timer_d = timer_q;
    sent_d  = sent_q;
    evt_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.abort_in) begin
          state_d = IDLE;
        end else if (bus.start_in) begin
          n_d    = bus.count_in;
          p_d    = p_eff;
          sent_d = '0;
          if (bus.count_in != '0) begin
            // First pulse leaves together with the RUN entry.
            state_d = RUN;
            evt_d   = 1'b1;
            busy_d  = 1'b1;
            sent_d  = ONE;
            timer_d = p_eff - ONE;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (bus.abort_in) begin
          state_d = IDLE;
        end else if (sent_q == n_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          // Timer counts down from P-1; a pulse fires and reloads it at zero.
          if (timer_q == '0) begin
            evt_d   = 1'b1;
            sent_d  = sent_q + ONE;
            timer_d = p_q - ONE;
          end else begin
            timer_d = timer_q - ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      n_q     <= '0;
      p_q     <= '0;
      timer_q <= '0;
      sent_q  <= '0;
      evt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      p_q     <= p_d;
      timer_q <= timer_d;
      sent_q  <= sent_d;
      evt_q   <= evt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.evt_out  = evt_q;
  assign bus.busy_out = busy_q;
  assign bus.done_out = done_q;
  assign bus.sent_out = sent_q;
endmodule

// File: tb/tb_evt_pulse_gen.sv
// Bench for evt_pulse_gen: directed scenarios then random traffic, checked against
// an arithmetic burst-schedule model (pulse k of a burst accepted at t lands at t+1+k*P).
module tb_evt_pulse_gen;
  localparam int W = 8;

  logic clk_in = 1'b0;
  logic rst_n_in;
  always #5 clk_in = ~clk_in;

  evt_pulse_gen_if #(.WIDTH(W)) bus();
  evt_pulse_gen #(.WIDTH(W)) dut (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Model: the current burst's acceptance cycle, length and effective period.
  longint cyc  = 0;
  bit     live = 1'b0;
  longint t0   = 0;
  longint mn   = 0;
  longint mp   = 1;
  longint hold = 0;

  function automatic longint last_pulse();
    return t0 + 1 + (mn - 1) * mp;
  endfunction

  function automatic bit in_run(longint c);
    return live && mn > 0 && c >= t0 + 1 && c <= last_pulse();
  endfunction

  function automatic longint sent_at(longint c);
    longint k;
    if (!live) return hold;
    if (mn == 0 || c < t0 + 1) return 0;
    k = (c - t0 - 1) / mp + 1;
    return (k < mn) ? k : mn;
  endfunction

  function automatic bit evt_at(longint c);
    return live && mn > 0 && c >= t0 + 1 && ((c - t0 - 1) % mp) == 0 && ((c - t0 - 1) / mp) < mn;
  endfunction

  function automatic bit done_at(longint c);
    return live && c == ((mn == 0) ? t0 + 1 : last_pulse() + 1);
  endfunction

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check outputs mid-cycle.
  task automatic step(bit st, logic [W-1:0] n, logic [W-1:0] p, bit ab, bit rs);
    bus.start_in  = st;
    bus.count_in  = n;
    bus.period_in = p;
    bus.abort_in  = ab;
    rst_n_in      = rs;
    @(posedge clk_in);
    if (!rs) begin
      live = 1'b0;
      hold = 0;
    end else if (ab) begin
      hold = sent_at(cyc);
      live = 1'b0;
    end else if (st && !in_run(cyc)) begin
      t0   = cyc;
      mn   = longint'(n);
      mp   = longint'(p);
      if (mp == 0) mp = 1;
      live = 1'b1;
    end
    cyc++;
    @(negedge clk_in);
    chk("evt",  W'(bus.evt_out),  W'(evt_at(cyc)));
    chk("busy", W'(bus.busy_out), W'(in_run(cyc)));
    chk("done", W'(bus.done_out), W'(done_at(cyc)));
    chk("sent", bus.sent_out,     W'(sent_at(cyc)));
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.start_in = 1'b0; bus.count_in = '0; bus.period_in = '0; bus.abort_in = 1'b0;
    rst_n_in = 1'b0;
    @(negedge clk_in);
    // Reset with a start pending: reset must win.
    step(1'b1, 8'd3, 8'd2, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    idle(3);

    // N=3 P=4: pulses t+1, t+5, t+9; done after the third.
    step(1'b1, 8'd3, 8'd4, 1'b0, 1'b1);
    idle(12);
    chk("sent_n3p4", bus.sent_out, 8'd3);

    // N=4 P=0: four consecutive pulses.
    step(1'b1, 8'd4, 8'd0, 1'b0, 1'b1);
    idle(7);

    // N=0 P=5: done only.
    step(1'b1, 8'd0, 8'd5, 1'b0, 1'b1);
    idle(3);

    // N=5 P=3: abort one cycle after the second pulse, then restart.
    step(1'b1, 8'd5, 8'd3, 1'b0, 1'b1);
    idle(4);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    idle(6);
    chk("sent_abort", bus.sent_out, 8'd2);
    step(1'b1, 8'd1, 8'd1, 1'b0, 1'b1);
    idle(3);

    // N=2 P=2: start during RUN ignored, start in DONE taken; inputs wiggle mid-run.
    step(1'b1, 8'd2, 8'd2, 1'b0, 1'b1);
    step(1'b1, 8'd7, 8'd1, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 8'd1, 8'd1, 1'b0, 1'b1);
    idle(4);

    // Reset mid-RUN.
    step(1'b1, 8'd6, 8'd2, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 8'd3, 8'd1, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 8'd1, 8'd0, 1'b0, 1'b1);
    idle(3);

    // Abort in the last-pulse cycle suppresses done.
    step(1'b1, 8'd2, 8'd3, 1'b0, 1'b1);
    idle(3);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    idle(3);

    // Abort together with start in IDLE: abort wins.
    step(1'b1, 8'd3, 8'd1, 1'b1, 1'b1);
    idle(3);

    // Maximum period: no timer wrap.
    step(1'b1, 8'd2, 8'd255, 1'b0, 1'b1);
    idle(260);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit st, ab, rs;
      logic [W-1:0] n, p;
      st = ($urandom_range(0, 7) == 0);
      ab = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 199) != 0);
      n  = W'($urandom_range(0, 6));
      p  = ($urandom_range(0, 49) == 0) ? W'($urandom_range(7, 20)) : W'($urandom_range(0, 5));
      step(st, n, p, ab, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/evt_pulse_gen.md
EVT_PULSE_GEN -- requirements
Module: evt_pulse_gen

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, width of count, period and pulse-tally fields.
REQ-002 SHALL provide port clk_in  input  1  system clock; all logic on rising edge.
REQ-003 SHALL provide port rst_n_in  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port start_in  input  1  request a burst; sampled every cycle.
REQ-005 SHALL provide port count_in  input  WIDTH  number of pulses in the burst; sampled only on an accepted start.
REQ-006 SHALL provide port period_in  input  WIDTH  cycles between pulse rising edges; sampled only on an accepted start.
REQ-007 SHALL provide port abort_in  input  1  cancel any burst in progress.
REQ-008 SHALL provide port evt_out  output  1  single-cycle event pulse, intended to drive an event counter's evt_in.
REQ-009 SHALL provide port busy_out  output  1  burst in progress.
REQ-010 SHALL provide port done_out  output  1  one-cycle completion strobe.
REQ-011 SHALL provide port sent_out  output  WIDTH  pulses emitted in current/last burst.

Function
REQ-012 SHALL implement FSM with states IDLE, RUN, DONE; all outputs registered.
REQ-013 Start SHALL be accepted when state is IDLE or DONE, start_in=1, abort_in=0; otherwise start_in is ignored (no queuing).
REQ-014 On acceptance at cycle t: latch count_in as N, latch period_in as P, clear sent_out to 0.
REQ-015 P=0 SHALL be treated as P=1 (back-to-back pulses).
REQ-016 N>0: SHALL enter RUN; evt_out=1 at cycles t+1, t+1+P, ..., t+1+(N-1)P, and 0 on all other cycles.
REQ-017 sent_out SHALL increment by 1 in the same cycle evt_out is 1; it SHALL reach N on the last pulse.
REQ-018 busy_out SHALL be 1 from t+1 through the cycle of the last pulse inclusive, and 0 otherwise.
REQ-019 Cycle after last pulse: SHALL enter DONE, done_out=1 for exactly that cycle, busy_out=0.
REQ-020 DONE SHALL return to IDLE after one cycle unless a start is accepted in DONE; a start accepted in DONE SHALL give its first pulse the next cycle.
REQ-021 N=0: SHALL emit no pulse; done_out=1 at t+1; state DONE at t+1; busy_out stays 0.
REQ-022 Inter-pulse timer SHALL be a WIDTH-bit down-counter loaded with P-1 on each pulse; the next pulse fires when it reaches 0; no wrap-around at P=2^WIDTH-1.
REQ-023 abort_in=1 in RUN SHALL produce, next cycle: state IDLE, evt_out=0, busy_out=0, done_out=0; sent_out holds its last value.
REQ-024 abort_in=1 in IDLE/DONE SHALL force IDLE next cycle; a simultaneous start SHALL be ignored (abort wins).
REQ-025 Abort coinciding with the cycle of the last pulse SHALL suppress done_out.
REQ-026 Changes on count_in/period_in during RUN SHALL have no effect.
REQ-027 sent_out SHALL hold after DONE/abort until the next accepted start.

Reset
REQ-028 rst_n_in=0 at a rising edge SHALL force IDLE, evt_out=0, busy_out=0, done_out=0, sent_out=0, timer=0, latched N/P=0, overriding all other inputs.
REQ-029 Reset mid-RUN SHALL abandon the burst without done_out; first start accepted is the first cycle rst_n_in=1 with start_in=1.

Verification
REQ-030 N=3, P=4, start at t=10 -> evt_out at 11,15,19; busy 11..19; done_out at 20; sent_out=3.
REQ-031 N=4, P=0 -> evt_out high 4 consecutive cycles t+1..t+4; done_out at t+5.
REQ-032 N=0, P=5 -> no evt_out; done_out at t+1; busy_out never 1.
REQ-033 N=5, P=3, abort one cycle after 2nd pulse -> no further pulses, no done_out, sent_out=2, start re-accepted afterwards.
REQ-034 N=2, P=2, second start during RUN and a start in the DONE cycle -> first ignored; second produces pulse at DONE+1.
REQ-035 rst_n_in=0 during RUN for 1 cycle -> all outputs 0 next cycle; no pulse until new start.
